// File: rtl/router_reg_param.sv
// Packet register stage: header capture, FIFO write path with a small hold buffer, XOR/CRC and length checks.
// One-cycle latency to data_out; bytes arriving while the FIFO is full are parked and replayed in LAF.

module router_reg_hold_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 2,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push_vld,
   input  logic [W-1:0]  push_dat,
   input  logic          pop_rdy,
   output logic [W-1:0]  pop_dat,
   output logic [CW-1:0] cnt,
   output logic          full
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [W-1:0]  mem_d [DEPTH];
   logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          do_push, do_pop;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full    = (cnt_q == CW'(DEPTH));
   assign cnt     = cnt_q;
   assign pop_dat = mem_q[rd_q];
   assign do_push = push_vld & ~full;
   assign do_pop  = pop_rdy & (cnt_q != '0);

   always_comb begin
      mem_d = mem_q;
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (do_push) begin
         mem_d[wr_q] = push_dat;
         wr_d        = nxt(wr_q);
      end
      if (do_pop)
         rd_d = nxt(rd_q);
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++)
            mem_q[i] <= '0;
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         mem_q <= mem_d;
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end
endmodule

module router_reg_param #(
   parameter int                    DATA_WIDTH  = 8,
   parameter int                    ADDR_BITS   = 2,
   parameter int                    PARITY_MODE = 0,
   parameter logic [DATA_WIDTH-1:0] CRC_POLY    = 'h07,
   parameter int                    HOLD_DEPTH  = 2
) (
   input  logic                              clockr,
   input  logic                              resetnr,
   input  logic                              pkt_validr,
   input  logic [DATA_WIDTH-1:0]             data_inr,
   input  logic                              fifo_fullr,
   input  logic                              detect_addr,
   input  logic                              lfd_state,
   input  logic                              ld_stater,
   input  logic                              laf_stater,
   input  logic                              full_stater,
   input  logic                              rst_int_regr,
   output logic [DATA_WIDTH-1:0]             data_out,
   output logic                              data_out_vld,
   output logic                              parity_doner,
   output logic                              low_pkt_validr,
   output logic                              err,
   output logic                              len_err,
   output logic                              hold_ovf,
   output logic [$clog2(HOLD_DEPTH+1)-1:0]   hold_cnt
);
   localparam int LW = DATA_WIDTH - ADDR_BITS;
   localparam int HW = $clog2(HOLD_DEPTH + 1);

   logic [DATA_WIDTH-1:0] hdr_q, hdr_d, calc_par_q, calc_par_d, pkt_par_q, pkt_par_d;
   logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
   logic [LW-1:0]         cnt_q, cnt_d;
   logic                  cnt_ovr_q, cnt_ovr_d;
   logic                  vld_q, vld_d, par_cap_q, par_cap_d;
   logic                  done_q, done_d, done_dly_q, done_dly_d;
   logic                  low_q, low_d, err_q, err_d, len_err_q, len_err_d, ovf_q, ovf_d;

   logic [DATA_WIDTH-1:0] hold_dat;
   logic [HW-1:0]         hold_cnt_w;
   logic                  hold_full, hold_push, hold_pop;
   logic                  pay_byte, par_byte, fwd_byte, use_hold;

   function automatic logic [DATA_WIDTH-1:0] upd(input logic [DATA_WIDTH-1:0] p,
                                                 input logic [DATA_WIDTH-1:0] d);
      logic [DATA_WIDTH-1:0] r;
      logic                  fb;
      r = p;
      if (PARITY_MODE == 0) begin
         r = p ^ d;
      end else begin
         for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
            fb = r[DATA_WIDTH-1] ^ d[i];
            r  = {r[DATA_WIDTH-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
         end
      end
      return r;
   endfunction

   // Parity byte is taken once per packet; it still travels to the FIFO like payload.
   assign pay_byte  = ld_stater & pkt_validr;
   assign par_byte  = ld_stater & ~pkt_validr & ~low_q;
   assign fwd_byte  = pay_byte | par_byte;
   assign use_hold  = fifo_fullr | (hold_cnt_w != '0);
   assign hold_push = fwd_byte & use_hold;
   assign hold_pop  = laf_stater & ~fifo_fullr & (hold_cnt_w != '0);

   router_reg_hold_fifo #(
      .W     (DATA_WIDTH),
      .DEPTH (HOLD_DEPTH),
      .CW    (HW)
   ) u_hold (
      .clk      (clockr),
      .rst_n    (resetnr),
      .push_vld (hold_push & ~hold_full),
      .push_dat (data_inr),
      .pop_rdy  (hold_pop),
      .pop_dat  (hold_dat),
      .cnt      (hold_cnt_w),
      .full     (hold_full)
   );

   always_comb begin
      hdr_d      = hdr_q;
      calc_par_d = calc_par_q;
      pkt_par_d  = pkt_par_q;
      data_out_d = data_out_q;
      cnt_d      = cnt_q;
      cnt_ovr_d  = cnt_ovr_q;
      vld_d      = 1'b0;
      par_cap_d  = 1'b0;
      done_d     = done_q;
      done_dly_d = done_q;
      low_d      = low_q;
      err_d      = err_q;
      len_err_d  = len_err_q;
      ovf_d      = ovf_q;

      if (detect_addr & pkt_validr) begin
         hdr_d      = data_inr;
         calc_par_d = '0;
         cnt_d      = '0;
         cnt_ovr_d  = 1'b0;
         done_d     = 1'b0;
         err_d      = 1'b0;
         len_err_d  = 1'b0;
         ovf_d      = 1'b0;
      end
      if (lfd_state) begin
         data_out_d = hdr_q;
         vld_d      = 1'b1;
         calc_par_d = upd('0, hdr_q);
      end
      if (pay_byte) begin
         calc_par_d = upd(calc_par_q, data_inr);
         if (cnt_q == '1)
            cnt_ovr_d = 1'b1;
         else
            cnt_d = cnt_q + 1'b1;
      end
      if (rst_int_regr)
         low_d = 1'b0;
      if (par_byte) begin
         pkt_par_d = data_inr;
         low_d     = 1'b1;
         par_cap_d = 1'b1;
      end
      if (fwd_byte & ~use_hold) begin
         data_out_d = data_inr;
         vld_d      = 1'b1;
      end
      if (hold_pop) begin
         data_out_d = hold_dat;
         vld_d      = 1'b1;
      end
      if (hold_push & hold_full)
         ovf_d = 1'b1;
      if (par_cap_q | (laf_stater & low_q & ~done_q))
         done_d = 1'b1;
      // Checks settle one cycle after parity_doner so calc_par includes every byte.
      if (done_q & ~done_dly_q) begin
         err_d     = (calc_par_q != pkt_par_q);
         len_err_d = (cnt_q != hdr_q[DATA_WIDTH-1:ADDR_BITS]) | cnt_ovr_q;
      end
   end

   always_ff @(posedge clockr or negedge resetnr) begin
      if (!resetnr) begin
         hdr_q      <= '0;
         calc_par_q <= '0;
         pkt_par_q  <= '0;
         data_out_q <= '0;
         cnt_q      <= '0;
         cnt_ovr_q  <= 1'b0;
         vld_q      <= 1'b0;
         par_cap_q  <= 1'b0;
         done_q     <= 1'b0;
         done_dly_q <= 1'b0;
         low_q      <= 1'b0;
         err_q      <= 1'b0;
         len_err_q  <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         hdr_q      <= hdr_d;
         calc_par_q <= calc_par_d;
         pkt_par_q  <= pkt_par_d;
         data_out_q <= data_out_d;
         cnt_q      <= cnt_d;
         cnt_ovr_q  <= cnt_ovr_d;
         vld_q      <= vld_d;
         par_cap_q  <= par_cap_d;
         done_q     <= done_d;
         done_dly_q <= done_dly_d;
         low_q      <= low_d;
         err_q      <= err_d;
         len_err_q  <= len_err_d;
         ovf_q      <= ovf_d;
      end
   end

   assign data_out       = data_out_q;
   assign data_out_vld   = vld_q;
   assign parity_doner   = done_q;
   assign low_pkt_validr = low_q;
   assign err            = err_q;
   assign len_err        = len_err_q;
   assign hold_ovf       = ovf_q;
   assign hold_cnt       = hold_cnt_w;
endmodule

// File: tb/tb_router_reg_param.sv
// Bench for router_reg_param: XOR and CRC instances share stimulus, checked against a transaction-level model.

module tb_router_reg_param;
   typedef logic [7:0] u8;
   localparam int HD = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic resetnr, pkt_validr, fifo_fullr, detect_addr, lfd_state, ld_stater;
   logic laf_stater, full_stater, rst_int_regr;
   u8    data_inr;

   u8          dout0, dout1;
   logic       vld0, vld1, done0, done1, low0, low1, err0, err1, len0, len1, ovf0, ovf1;
   logic [1:0] hc0, hc1;

   router_reg_param #(.PARITY_MODE(0), .HOLD_DEPTH(HD)) dut (
      .clockr(clk), .resetnr(resetnr), .pkt_validr(pkt_validr), .data_inr(data_inr),
      .fifo_fullr(fifo_fullr), .detect_addr(detect_addr), .lfd_state(lfd_state),
      .ld_stater(ld_stater), .laf_stater(laf_stater), .full_stater(full_stater),
      .rst_int_regr(rst_int_regr), .data_out(dout0), .data_out_vld(vld0),
      .parity_doner(done0), .low_pkt_validr(low0), .err(err0), .len_err(len0),
      .hold_ovf(ovf0), .hold_cnt(hc0));

   router_reg_param #(.PARITY_MODE(1), .CRC_POLY(8'h07), .HOLD_DEPTH(HD)) dut_crc (
      .clockr(clk), .resetnr(resetnr), .pkt_validr(pkt_validr), .data_inr(data_inr),
      .fifo_fullr(fifo_fullr), .detect_addr(detect_addr), .lfd_state(lfd_state),
      .ld_stater(ld_stater), .laf_stater(laf_stater), .full_stater(full_stater),
      .rst_int_regr(rst_int_regr), .data_out(dout1), .data_out_vld(vld1),
      .parity_doner(done1), .low_pkt_validr(low1), .err(err1), .len_err(len1),
      .hold_ovf(ovf1), .hold_cnt(hc1));

   int n_tests = 0;
   int n_fail  = 0;
   u8  got0[$], got1[$], hq[$], exp_out[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (resetnr && vld0) got0.push_back(dout0);
      if (resetnr && vld1) got1.push_back(dout1);
   end

   function automatic u8 xor_ref(input u8 m[$]);
      u8 r = 8'h00;
      foreach (m[i]) r ^= m[i];
      return r;
   endfunction

   // CRC as remainder of the message times x^8 divided by x^8+x^2+x+1.
   function automatic u8 crc_ref(input u8 m[$]);
      u8  r = 8'h00;
      u8  aug[$];
      logic top;
      aug = m;
      aug.push_back(8'h00);
      foreach (aug[i])
         for (int b = 7; b >= 0; b--) begin
            top = r[7];
            r   = {r[6:0], aug[i][b]};
            if (top) r ^= 8'h07;
         end
      return r;
   endfunction

   task automatic step(input logic det, input logic lfd, input logic ld, input logic laf,
                       input logic pv, input logic full, input logic ri, input u8 d);
      @(negedge clk);
      detect_addr = det; lfd_state = lfd; ld_stater = ld; laf_stater = laf;
      pkt_validr = pv; fifo_fullr = full; rst_int_regr = ri; data_inr = d;
      full_stater = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 0, 0, 8'h00);
   endtask

   task automatic drain(input string tag);
      logic full;
      for (int c = 0; c < 200 && hq.size() > 0; c++) begin
         full = ($urandom_range(0, 99) < 30);
         step(0, 0, 0, 1, 0, full, 0, 8'h00);
         if (!full) exp_out.push_back(hq.pop_front());
         chk({tag, ".laf_hold_cnt"}, hc0, hq.size());
      end
      if (hq.size() > 0) chk({tag, ".drain_timeout"}, hc0, 0);
   endtask

   task automatic run_pkt(input string tag, input u8 hdr, input u8 pay[$], input u8 par,
                          input logic [31:0] fmask);
      u8    bytes[$], msg[$];
      logic full;
      bit   ovf;
      got0.delete(); got1.delete(); hq.delete(); exp_out.delete();
      ovf = 0;
      exp_out.push_back(hdr);
      bytes = pay; bytes.push_back(par);
      msg = pay;   msg.push_front(hdr);
      step(1, 0, 0, 0, 1, 0, 0, hdr);
      step(0, 1, 0, 0, 0, 0, 0, 8'h00);
      foreach (bytes[i]) begin
         full = (i < 32) ? fmask[i] : 1'b0;
         if (!full && hq.size() > 0) drain(tag);
         step(0, 0, 1, 0, (i < pay.size()), full, 0, bytes[i]);
         if (full || hq.size() > 0) begin
            if (hq.size() < HD) hq.push_back(bytes[i]);
            else ovf = 1;
         end else exp_out.push_back(bytes[i]);
         chk({tag, ".hold_cnt"}, hc0, hq.size());
         chk({tag, ".hold_cnt_crc"}, hc1, hq.size());
      end
      chk({tag, ".doner_early"}, done0, 0);
      chk({tag, ".low_set"}, low0, 1);
      idle();
      chk({tag, ".doner"}, done0, 1);
      chk({tag, ".doner_crc"}, done1, 1);
      chk({tag, ".err_early"}, err0, 0);
      idle();
      chk({tag, ".err_xor"}, err0, xor_ref(msg) != par);
      chk({tag, ".err_crc"}, err1, crc_ref(msg) != par);
      chk({tag, ".len_err"}, len0, pay.size() != int'(hdr[7:2]));
      chk({tag, ".len_err_crc"}, len1, pay.size() != int'(hdr[7:2]));
      drain(tag);
      idle();
      chk({tag, ".out_count"}, got0.size(), exp_out.size());
      chk({tag, ".out_count_crc"}, got1.size(), exp_out.size());
      foreach (exp_out[i]) begin
         if (i < got0.size()) chk($sformatf("%s.out%0d", tag, i), got0[i], exp_out[i]);
         if (i < got1.size()) chk($sformatf("%s.out%0d_crc", tag, i), got1[i], exp_out[i]);
      end
      chk({tag, ".hold_ovf"}, ovf0, ovf);
      chk({tag, ".hold_ovf_crc"}, ovf1, ovf);
      step(0, 0, 0, 0, 0, 0, 1, 8'h00);
      chk({tag, ".low_clr"}, low0, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
      $fatal(1);
   end

   initial begin
      u8 pay[$];
      u8 hdr, par, c;
      int len, n, k;
      logic [31:0] m;

      resetnr = 0; pkt_validr = 0; fifo_fullr = 0; detect_addr = 0; lfd_state = 0;
      ld_stater = 0; laf_stater = 0; full_stater = 0; rst_int_regr = 0; data_inr = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      chk("rst.data_out", dout0, 0);
      chk("rst.vld", vld0, 0);
      chk("rst.flags", {done0, low0, err0, len0, ovf0}, 0);
      chk("rst.hold_cnt", hc0, 0);
      @(negedge clk) resetnr = 1;

      run_pkt("t1", 8'h0D, '{8'h11, 8'h22, 8'h33}, 8'h0D, 32'h0);
      run_pkt("t2", 8'h0D, '{8'h11, 8'h22, 8'h33}, 8'h0E, 32'h0);
      run_pkt("t3", 8'h0D, '{8'h11, 8'h22, 8'h33}, 8'h0D, 32'h6);
      run_pkt("t4", 8'h0D, '{8'h11, 8'h22, 8'h33}, 8'h0D, 32'h7);
      c = crc_ref('{8'h04, 8'h01});
      run_pkt("t5a", 8'h04, '{8'h01}, c, 32'h0);
      run_pkt("t5b", 8'h04, '{8'h01}, c ^ 8'h01, 32'h0);
      run_pkt("t6", 8'h0D, '{8'h11, 8'h22}, 8'h2E, 32'h0);
      run_pkt("len0", 8'h01, '{}, 8'h01, 32'h1);

      for (int p = 0; p < 25; p++) begin
         len = $urandom_range(0, 10);
         hdr = {len[5:0], 2'($urandom_range(0, 3))};
         n = len;
         k = $urandom_range(0, 3);
         if (k == 0) n = len + 1;
         if (k == 1 && len > 0) n = len - 1;
         pay.delete();
         for (int i = 0; i < n; i++) pay.push_back(u8'($urandom_range(0, 255)));
         m = 32'h0;
         for (int i = 0; i < 32; i++) m[i] = ($urandom_range(0, 99) < 30);
         k = $urandom_range(0, 3);
         if (k < 2)       par = xor_ref({hdr, pay});
         else if (k == 2) par = crc_ref({hdr, pay});
         else             par = u8'($urandom_range(0, 255));
         run_pkt($sformatf("rnd%0d", p), hdr, pay, par, m);
      end

      // Reset in the middle of a packet with bytes parked in the hold buffer.
      step(1, 0, 0, 0, 1, 0, 0, 8'h0D);
      step(0, 1, 0, 0, 0, 0, 0, 8'h00);
      step(0, 0, 1, 0, 1, 1, 0, 8'h11);
      step(0, 0, 1, 0, 1, 1, 0, 8'h22);
      chk("midrst.hold_before", hc0, 2);
      #2;
      resetnr = 0;
      #1;
      got0.delete();
      chk("midrst.data_out", dout0, 0);
      chk("midrst.vld", vld0, 0);
      chk("midrst.hold_cnt", hc0, 0);
      chk("midrst.flags", {done0, low0, err0, len0, ovf0}, 0);
      @(negedge clk);
      resetnr = 1;
      ld_stater = 0; fifo_fullr = 0; pkt_validr = 0;
      repeat (3) idle();
      step(0, 0, 0, 1, 0, 0, 0, 8'h00);
      idle();
      chk("midrst.no_vld", got0.size(), 0);
      chk("midrst.hold_after", hc0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
